// File: rtl/drum_pkg.sv
// Shared types and default constants for the drum stick pipeline.
package drum_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READY    = 2'd1,
    SWING    = 2'd2,
    COOLDOWN = 2'd3
  } det_state_e;

  localparam int SWING_THRESH_DEF   = 2000;
  localparam int RELEASE_THRESH_DEF = 500;
  localparam int MAX_SWING_DEF      = 64;
  localparam int COOLDOWN_DEF       = 150000;

endpackage

// File: rtl/strike_detector_if.sv
// Gyro sample bundle from the sensor controller.
interface strike_detector_if;
  logic        initialized;
  logic        gyro_valid;
  logic [15:0] gyro_y;

  modport master (
    output initialized,
    output gyro_valid,
    output gyro_y
  );

  modport slave (
    input initialized,
    input gyro_valid,
    input gyro_y
  );
endinterface

// File: rtl/strike_detector.sv
// Detects downward stick swings from pitch rate and emits strikes.
module strike_detector
  import drum_pkg::*;
#(
  parameter int SWING_THRESH      = SWING_THRESH_DEF,
  parameter int RELEASE_THRESH    = RELEASE_THRESH_DEF,
  parameter int MAX_SWING_SAMPLES = MAX_SWING_DEF,
  parameter int COOLDOWN_CYCLES   = COOLDOWN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        initialized,
  input  logic        gyro_valid,
  input  logic [15:0] gyro_y,
  output logic        strike,
  output logic [6:0]  strike_velocity,
  output logic [7:0]  strike_count,
  output logic [1:0]  state_dbg
);

  localparam int CW = $clog2(COOLDOWN_CYCLES + 1);
  localparam int SW = $clog2(MAX_SWING_SAMPLES + 1);

  localparam logic [14:0] SW_T = 15'(SWING_THRESH);
  localparam logic [14:0] RL_T = 15'(RELEASE_THRESH);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_SWING_SAMPLES);
  localparam logic [CW-1:0] CD_LD = CW'(COOLDOWN_CYCLES - 1);

  det_state_e   state;
  logic [14:0]  peak;
  logic [SW-1:0] sample_cnt;
  logic [CW-1:0] cd_cnt;

  logic [14:0]  down;
  logic [15:0]  neg_y;
  logic [SW-1:0] cnt_nx;
  logic [6:0]   vel;

  assign neg_y = 16'(-gyro_y);

  always_comb begin
    down = 15'd0;
    if (gyro_y == 16'h8000)
      down = 15'h7fff;
    else if (gyro_y[15])
      down = neg_y[14:0];
  end

  assign cnt_nx = sample_cnt + 1'b1;
  assign vel = (peak[14:8] == 7'd0) ? 7'd1 : peak[14:8];
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      peak            <= '0;
      sample_cnt      <= '0;
      cd_cnt          <= '0;
      strike          <= 1'b0;
      strike_velocity <= '0;
      strike_count    <= '0;
    end else begin
      strike <= 1'b0;
      if (!initialized) begin
        state      <= IDLE;
        peak       <= '0;
        sample_cnt <= '0;
        cd_cnt     <= '0;
      end else begin
        unique case (state)
          IDLE: state <= READY;
          READY: begin
            if (gyro_valid && down >= SW_T) begin
              state      <= SWING;
              peak       <= down;
              sample_cnt <= SW'(1);
            end
          end
          SWING: begin
            if (gyro_valid) begin
              sample_cnt <= cnt_nx;
              if (down > peak)
                peak <= down;
              if (down < RL_T) begin
                state           <= COOLDOWN;
                cd_cnt          <= CD_LD;
                strike          <= 1'b1;
                strike_velocity <= vel;
                strike_count    <= strike_count + 8'd1;
              end else if (cnt_nx == MAX_S) begin
                state <= READY;
              end
            end
          end
          COOLDOWN: begin
            if (cd_cnt == '0)
              state <= READY;
            else
              cd_cnt <= cd_cnt - 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
